osd_ring_router: RTL and testbench
==================================

# osd_ring_router

Parametrised debug-ring station that attaches `PORTS` local debug modules to one DII ring segment, generalising the fixed four-port ring expansion used in the debug system. It buffers incoming ring traffic and delivers packets whose destination ID matches a local port, forwarding all others. It merges local outbound packets and forwarded traffic onto the ring with packet-atomic round-robin arbitration. It sits between the HIM/SCM/UART/MAM modules and the inter-tile ring ports.

## Interface
- `PORTS`, 4: number of local debug modules, 1..16.
- `ID_WIDTH`, 10: debug module ID width; destination is header flit `data[ID_WIDTH-1:0]`.
- `FIFO_DEPTH`, 4: ring-input buffer depth in flits, power of two, ≥2.
- `clk` input 1: clock.
- `rstn` input 1: reset. Reset is asynchronous and active-low.
- `id_map` input `PORTS*ID_WIDTH`: ID of local port i at `[i*ID_WIDTH +: ID_WIDTH]`; static after reset.
- `ring_in` input `dii_flit`: incoming ring flit.
- `ring_in_ready` output 1: ring input accept.
- `ring_out` output `dii_flit`: outgoing ring flit (registered).
- `ring_out_ready` input 1: downstream accept.
- `dii_in` input `dii_flit [PORTS-1:0]`: flits from local modules toward the ring.
- `dii_in_ready` output `PORTS`: local inbound accepts.
- `dii_out` output `dii_flit [PORTS-1:0]`: flits to local modules.
- `dii_out_ready` input `PORTS`: local module accepts.
- `perf_fwd_pkts`, `perf_local_pkts`, `perf_stall_cycles` output 32 each: performance counters (see Configuration).

## Operation
- Flit transfer occurs when `valid && ready` on the same rising edge. A packet ends with the flit having `last=1`. The next flit is a header.
- Ring input path:
  - `ring_in` is written into the FIFO. `ring_in_ready = !full`.
  - No same-cycle pass-through when full: a pop does not raise ready in that cycle.
- Delivery FSM on the FIFO head, states `IDLE`, `LOCAL(i)`, `FWD`:
  - `IDLE`: on a valid head, compare dest to each `id_map` entry. The lowest matching index i moves the FSM to `LOCAL(i)`. No match moves it to `FWD`.
  - The routing decision is combinational in the head cycle, so the header itself is presented to its target in that same cycle.
  - `LOCAL(i)`: head drives `dii_out[i]`. Pop on `dii_out_ready[i]`.
  - `FWD`: head is offered to the ring arbiter as source index `PORTS`.
  - Both `LOCAL(i)` and `FWD` return to `IDLE` after popping a `last` flit.
  - A stalled local port blocks the ring input; this is intended.
  - `dii_out[j].valid = 0` for every non-selected j.
- Ring output arbiter:
  - `PORTS+1` requesters: local 0..`PORTS-1` plus the forward path.
  - Round-robin: the pointer starts after the last granted index. Reset pointer = 0.
  - A grant is held until the `last` flit of that packet is transferred into the output register. There is no interleaving within a packet.
  - The output register loads when `!ring_out.valid || ring_out_ready`. Only the granted source sees ready.
- Reset mid-packet: all state clears, the FIFO empties, and partial packets are discarded. Upstream must also reset.

## Timing
- Reset values:
  - `ring_out.valid=0`, all `dii_out[*].valid=0`.
  - `ring_in_ready=1` (FIFO empty), `dii_in_ready=0`.
  - Counters 0, FSM `IDLE`, arbiter pointer 0.
- Latencies:
  - ring_in accepted at edge t → `dii_out[i]` valid in cycle t+1.
  - ring_in accepted at edge t → `ring_out` valid in cycle t+2.
  - `dii_in[i]` accepted at edge t → `ring_out` valid in cycle t+1.
- Throughput: one flit per cycle on each path when downstream ready stays high.
- `dii_in_ready[i]` depends combinationally on `ring_out_ready` and grant. `ring_out` has no combinational path from any input.

## Configuration
- `OSD_RING_PERF_EN` defined:
  - `perf_fwd_pkts` counts forwarded `last` flits.
  - `perf_local_pkts` counts delivered `last` flits.
  - `perf_stall_cycles` counts cycles with `ring_out.valid && !ring_out_ready`.
  - All counters saturate at 0xFFFF_FFFF and clear on reset.
- Not defined: the counter ports remain and are tied to 0. No counter logic is compiled.

## Structure
- Package `osd_ring_pkg` holds:
  - `route_state_t` enum (`ROUTE_IDLE`, `ROUTE_LOCAL`, `ROUTE_FWD`).
  - `PERF_CNT_W = 32`.
- `dii_flit` comes from `dii_package`.
- Sub-module `osd_ring_fifo`: synchronous FIFO with `DEPTH` parameter, `dii_flit` payload, full/empty, and async active-low reset.

## Test plan
- `PORTS=4`, `id_map={3,2,1,0}`; 3-flit packet dest=2 on ring_in → appears on `dii_out[2]` from cycle t+1; `ring_out` stays invalid.
- Dest=0x155 (no match), 2 flits → `ring_out` carries both unchanged, first at t+2. `perf_fwd_pkts` reads 1 with `OSD_RING_PERF_EN`, 0 without.
- Locals 0 and 3 plus the forward path all request 4-flit packets simultaneously → grant order 0, 3, 4 (forward). Each packet is contiguous with no interleaving.
- Hold `dii_out_ready[1]=0` with `FIFO_DEPTH=4` and stream 6 flits dest=1 → exactly 4 flits accepted and `ring_in_ready=0`. Releasing ready drains all flits in order.
- `ring_out_ready=0` for 10 cycles while a local packet is pending → `perf_stall_cycles=10` and the `ring_out` data is held stable.
- Assert `rstn=0` mid-packet → all valid outputs are 0 asynchronously. After release, a fresh packet routes correctly from `IDLE`.

Source files
------------

// File: rtl/dii_package.sv
// DII flit payload shared by all debug-interconnect blocks.
package dii_package;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic [15:0] data;
    } dii_flit;

endpackage

// File: rtl/osd_ring_pkg.sv
// Shared types, widths and helpers for the debug-ring router.
package osd_ring_pkg;

    localparam int unsigned PERF_CNT_W = 32;

    typedef enum logic [1:0] {
        ROUTE_IDLE,
        ROUTE_LOCAL,
        ROUTE_FWD
    } route_state_t;

    // Saturating increment for the performance counters.
    function automatic logic [PERF_CNT_W-1:0] sat_inc(input logic [PERF_CNT_W-1:0] v);
        return (&v) ? v : v + PERF_CNT_W'(1);
    endfunction

endpackage

// File: rtl/osd_ring_fifo.sv
// Synchronous flit FIFO buffering ring input; head is shown with valid = !empty.
module osd_ring_fifo
    import dii_package::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic    clk,
    input  logic    rstn,
    input  dii_flit i_wr,
    input  logic    i_pop,
    output dii_flit o_head,
    output logic    o_full,
    output logic    o_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW:0] r_wptr;
    logic [AW:0] r_rptr;
    dii_flit     r_mem [DEPTH];
    logic        w_push;
    logic        w_pop;

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_push  = i_wr.valid && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop)  r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wr;
    end

    always_comb begin
        o_head       = r_mem[r_rptr[AW-1:0]];
        o_head.valid = !o_empty;
    end

endmodule

// File: rtl/osd_ring_router.sv
// Debug-ring station: delivers ring packets to local ports by ID, forwards the rest,
// and merges local traffic onto the ring. Optional counters: define OSD_RING_PERF_EN.
module osd_ring_router
    import dii_package::*;
    import osd_ring_pkg::*;
#(
    parameter int unsigned PORTS      = 4,
    parameter int unsigned ID_WIDTH   = 10,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [PORTS*ID_WIDTH-1:0] id_map,
    input  dii_flit                   ring_in,
    output logic                      ring_in_ready,
    output dii_flit                   ring_out,
    input  logic                      ring_out_ready,
    input  dii_flit [PORTS-1:0]       dii_in,
    output logic    [PORTS-1:0]       dii_in_ready,
    output dii_flit [PORTS-1:0]       dii_out,
    input  logic    [PORTS-1:0]       dii_out_ready,
    output logic [PERF_CNT_W-1:0]     perf_fwd_pkts,
    output logic [PERF_CNT_W-1:0]     perf_local_pkts,
    output logic [PERF_CNT_W-1:0]     perf_stall_cycles
);

    localparam int unsigned SEL_W = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int unsigned NSRC  = PORTS + 1;
    localparam int unsigned SRC_W = $clog2(NSRC);

    dii_flit            w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_match;
    logic [SEL_W-1:0]   w_match_idx;
    logic               w_is_local;
    logic               w_is_fwd;
    logic [SEL_W-1:0]   w_idx;
    route_state_t       r_state;
    route_state_t       w_state_nxt;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   w_sel_nxt;

    dii_flit [PORTS:0]  w_src;
    logic [NSRC-1:0]    w_req;
    logic [NSRC-1:0]    w_src_rdy;
    logic               w_pick_vld;
    logic [SRC_W-1:0]   w_pick;
    logic               w_gnt_vld;
    logic [SRC_W-1:0]   w_gnt;
    dii_flit            w_gnt_flit;
    logic               w_load;
    logic               w_xfer;
    logic               w_fwd_ready;
    dii_flit            r_out;
    logic               r_lock;
    logic [SRC_W-1:0]   r_gidx;
    logic [SRC_W-1:0]   r_ptr;
    logic               r_arb_en;

    osd_ring_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .i_wr    (ring_in),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign ring_in_ready = !w_full;

    // Lowest-index local port whose ID equals the head destination.
    always_comb begin
        w_match     = 1'b0;
        w_match_idx = '0;
        for (int i = int'(PORTS) - 1; i >= 0; i--) begin
            if (w_head.data[ID_WIDTH-1:0] == id_map[i*ID_WIDTH +: ID_WIDTH]) begin
                w_match     = 1'b1;
                w_match_idx = SEL_W'(i);
            end
        end
    end

    // Routing of the current head: decided live in IDLE, held while mid-packet.
    always_comb begin
        w_is_local = 1'b0;
        w_is_fwd   = 1'b0;
        w_idx      = r_sel;
        case (r_state)
            ROUTE_IDLE: begin
                if (w_match) begin
                    w_is_local = !w_empty;
                    w_idx      = w_match_idx;
                end else begin
                    w_is_fwd   = !w_empty;
                end
            end
            ROUTE_LOCAL: w_is_local = !w_empty;
            ROUTE_FWD:   w_is_fwd   = !w_empty;
            default: ;
        endcase
    end

    assign w_pop = (w_is_local && dii_out_ready[w_idx]) || (w_is_fwd && w_fwd_ready);

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        case (r_state)
            ROUTE_IDLE: begin
                if (w_is_local) begin
                    w_state_nxt = ROUTE_LOCAL;
                    w_sel_nxt   = w_idx;
                end else if (w_is_fwd) begin
                    w_state_nxt = ROUTE_FWD;
                end
            end
            default: ;
        endcase
        if (w_pop && w_head.last) w_state_nxt = ROUTE_IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ROUTE_IDLE;
            r_sel   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
        end
    end

    always_comb begin
        for (int j = 0; j < int'(PORTS); j++) begin
            dii_out[j]       = w_head;
            dii_out[j].valid = w_is_local && (w_idx == SEL_W'(j));
        end
    end

    // Arbiter sources: local inputs 0..PORTS-1, forward path at index PORTS.
    always_comb begin
        w_src              = '0;
        w_src[PORTS-1:0]   = dii_in;
        w_src[PORTS]       = w_head;
        w_src[PORTS].valid = w_is_fwd;
        for (int k = 0; k < int'(NSRC); k++) w_req[k] = w_src[k].valid;
    end

    // Round-robin search starting at r_ptr; the smallest offset wins.
    always_comb begin : p_pick
        int unsigned v_cand;
        v_cand     = 0;
        w_pick_vld = 1'b0;
        w_pick     = '0;
        for (int off = int'(NSRC) - 1; off >= 0; off--) begin
            v_cand = 32'(r_ptr) + 32'(off);
            if (v_cand >= NSRC) v_cand = v_cand - NSRC;
            if (w_req[SRC_W'(v_cand)]) begin
                w_pick_vld = 1'b1;
                w_pick     = SRC_W'(v_cand);
            end
        end
    end

    assign w_gnt_vld  = r_lock || w_pick_vld;
    assign w_gnt      = r_lock ? r_gidx : w_pick;
    assign w_gnt_flit = w_src[w_gnt];
    assign w_load     = r_arb_en && (!r_out.valid || ring_out_ready);
    assign w_xfer     = w_load && w_gnt_vld && w_gnt_flit.valid;

    always_comb begin
        for (int k = 0; k < int'(NSRC); k++) begin
            w_src_rdy[k] = w_load && w_gnt_vld && (w_gnt == SRC_W'(k));
        end
    end

    assign dii_in_ready = w_src_rdy[PORTS-1:0];
    assign w_fwd_ready  = w_src_rdy[PORTS];

    // Output register; grant is locked from header to last flit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out    <= '0;
            r_lock   <= 1'b0;
            r_gidx   <= '0;
            r_ptr    <= '0;
            r_arb_en <= 1'b0;
        end else begin
            r_arb_en <= 1'b1;
            if (w_load) begin
                r_out <= w_xfer ? w_gnt_flit : '0;
                if (w_xfer) begin
                    if (w_gnt_flit.last) begin
                        r_lock <= 1'b0;
                        r_ptr  <= (w_gnt == SRC_W'(PORTS)) ? '0 : w_gnt + SRC_W'(1);
                    end else begin
                        r_lock <= 1'b1;
                        r_gidx <= w_gnt;
                    end
                end
            end
        end
    end

    assign ring_out = r_out;

`ifdef OSD_RING_PERF_EN
    logic [PERF_CNT_W-1:0] r_perf_fwd;
    logic [PERF_CNT_W-1:0] r_perf_local;
    logic [PERF_CNT_W-1:0] r_perf_stall;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_perf_fwd   <= '0;
            r_perf_local <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_pop && w_head.last && w_is_fwd)   r_perf_fwd   <= sat_inc(r_perf_fwd);
            if (w_pop && w_head.last && w_is_local) r_perf_local <= sat_inc(r_perf_local);
            if (r_out.valid && !ring_out_ready)     r_perf_stall <= sat_inc(r_perf_stall);
        end
    end

    assign perf_fwd_pkts     = r_perf_fwd;
    assign perf_local_pkts   = r_perf_local;
    assign perf_stall_cycles = r_perf_stall;
`else
    assign perf_fwd_pkts     = '0;
    assign perf_local_pkts   = '0;
    assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_osd_ring_router.sv
// Directed bench for osd_ring_router (PORTS=4, ids 0..3, FIFO_DEPTH=4).
module tb_osd_ring_router;
    import dii_package::*;
    import osd_ring_pkg::*;

    localparam int unsigned PORTS = 4;
    localparam int unsigned IDW   = 10;
    localparam int unsigned DEPTH = 4;
`ifdef OSD_RING_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic                  clk;
    logic                  rstn;
    logic [PORTS*IDW-1:0]  id_map;
    dii_flit               ring_in;
    logic                  ring_in_ready;
    dii_flit               ring_out;
    logic                  ring_out_ready;
    dii_flit [PORTS-1:0]   dii_in;
    logic    [PORTS-1:0]   dii_in_ready;
    dii_flit [PORTS-1:0]   dii_out;
    logic    [PORTS-1:0]   dii_out_ready;
    logic [PERF_CNT_W-1:0] perf_fwd_pkts;
    logic [PERF_CNT_W-1:0] perf_local_pkts;
    logic [PERF_CNT_W-1:0] perf_stall_cycles;

    int      n_vec;
    int      n_err;
    dii_flit rq[$];
    dii_flit lq[PORTS][$];
    dii_flit ro_log[$];
    dii_flit do_log[PORTS][$];
    dii_flit exp_q[$];

    osd_ring_router #(
        .PORTS      (PORTS),
        .ID_WIDTH   (IDW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .id_map            (id_map),
        .ring_in           (ring_in),
        .ring_in_ready     (ring_in_ready),
        .ring_out          (ring_out),
        .ring_out_ready    (ring_out_ready),
        .dii_in            (dii_in),
        .dii_in_ready      (dii_in_ready),
        .dii_out           (dii_out),
        .dii_out_ready     (dii_out_ready),
        .perf_fwd_pkts     (perf_fwd_pkts),
        .perf_local_pkts   (perf_local_pkts),
        .perf_stall_cycles (perf_stall_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic dii_flit mk(input logic l, input logic [15:0] d);
        dii_flit f;
        f.valid = 1'b1;
        f.last  = l;
        f.data  = d;
        return f;
    endfunction

    function automatic logic [31:0] pk(input dii_flit f);
        return {14'd0, f};
    endfunction

    function automatic logic [31:0] ov();
        logic [31:0] v;
        v = '0;
        for (int p = 0; p < int'(PORTS); p++) v[p] = dii_out[p].valid;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        ring_in = (rq.size() != 0) ? rq[0] : '0;
        for (int p = 0; p < int'(PORTS); p++) dii_in[p] = (lq[p].size() != 0) ? lq[p][0] : '0;
        #1;
    endtask

    // One clock: handshakes sampled at the falling edge, queues advanced after the rising edge.
    task automatic step();
        logic             ri_hs;
        logic [PORTS-1:0] li_hs;
        @(negedge clk);
        ri_hs = ring_in.valid && ring_in_ready;
        for (int p = 0; p < int'(PORTS); p++) li_hs[p] = dii_in[p].valid && dii_in_ready[p];
        if (ring_out.valid && ring_out_ready) ro_log.push_back(ring_out);
        for (int p = 0; p < int'(PORTS); p++)
            if (dii_out[p].valid && dii_out_ready[p]) do_log[p].push_back(dii_out[p]);
        @(posedge clk);
        #1;
        if (ri_hs) void'(rq.pop_front());
        for (int p = 0; p < int'(PORTS); p++) if (li_hs[p]) void'(lq[p].pop_front());
        drive();
    endtask

    task automatic clear_logs();
        ro_log.delete();
        for (int p = 0; p < int'(PORTS); p++) do_log[p].delete();
    endtask

    initial begin
        n_vec          = 0;
        n_err          = 0;
        id_map         = {10'd3, 10'd2, 10'd1, 10'd0};
        ring_in        = '0;
        dii_in         = '0;
        ring_out_ready = 1'b1;
        dii_out_ready  = 4'hF;
        rstn           = 1'b1;
        #2 rstn = 1'b0;
        #1;
        check("rst_ring_out_valid", {31'd0, ring_out.valid}, 32'd0);
        check("rst_dii_out_valid", ov(), 32'd0);
        check("rst_ring_in_ready", {31'd0, ring_in_ready}, 32'd1);
        check("rst_dii_in_ready", {28'd0, dii_in_ready}, 32'd0);
        check("rst_perf_fwd", perf_fwd_pkts, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rstn = 1'b1;
        drive();

        // Local delivery, dest 2: visible one cycle after acceptance.
        exp_q = {mk(1'b0, 16'h0002), mk(1'b0, 16'hA001), mk(1'b1, 16'hA002)};
        rq = exp_q;
        drive();
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("t2_dii_out2_flit%0d", k), pk(dii_out[2]), pk(exp_q[k]));
            check($sformatf("t2_ring_out_idle%0d", k), {31'd0, ring_out.valid}, 32'd0);
        end
        step();
        check("t2_dii_out_drained", ov(), 32'd0);
        check("t2_perf_local", perf_local_pkts, PERF ? 32'd1 : 32'd0);

        // Forward, dest 0x155: ring_out valid two cycles after acceptance.
        exp_q = {mk(1'b0, 16'h0155), mk(1'b1, 16'hBEEF)};
        rq = exp_q;
        drive();
        step();
        check("t3_ring_out_t1", {31'd0, ring_out.valid}, 32'd0);
        check("t3_no_local", ov(), 32'd0);
        step();
        check("t3_ring_out_hdr", pk(ring_out), pk(exp_q[0]));
        step();
        check("t3_ring_out_last", pk(ring_out), pk(exp_q[1]));
        step();
        check("t3_ring_out_idle", {31'd0, ring_out.valid}, 32'd0);
        check("t3_perf_fwd", perf_fwd_pkts, PERF ? 32'd1 : 32'd0);

        // Locals 0, 3 and the forward path contend: order 0, 3, forward.
        clear_logs();
        rq = {mk(1'b0, 16'h0155), mk(1'b0, 16'hF001), mk(1'b0, 16'hF002), mk(1'b1, 16'hF003)};
        drive();
        step();
        exp_q = {};
        for (int k = 0; k < 4; k++) begin
            lq[0].push_back(mk(k == 3, 16'h0A00 + 16'(k)));
            exp_q.push_back(mk(k == 3, 16'h0A00 + 16'(k)));
        end
        for (int k = 0; k < 4; k++) begin
            lq[3].push_back(mk(k == 3, 16'h3A00 + 16'(k)));
            exp_q.push_back(mk(k == 3, 16'h3A00 + 16'(k)));
        end
        exp_q.push_back(mk(1'b0, 16'h0155));
        exp_q.push_back(mk(1'b0, 16'hF001));
        exp_q.push_back(mk(1'b0, 16'hF002));
        exp_q.push_back(mk(1'b1, 16'hF003));
        drive();
        check("t4_first_grant", {28'd0, dii_in_ready}, 32'h1);
        for (int i = 0; i < 60 && ro_log.size() < 12; i++) step();
        check("t4_flit_count", 32'(ro_log.size()), 32'd12);
        for (int k = 0; k < 12; k++)
            check($sformatf("t4_order%0d", k),
                  (k < ro_log.size()) ? pk(ro_log[k]) : 32'hDEAD0000, pk(exp_q[k]));
        check("t4_perf_fwd", perf_fwd_pkts, PERF ? 32'd2 : 32'd0);

        // Stalled local port 1 fills the FIFO and blocks the ring input.
        clear_logs();
        exp_q = {mk(1'b0, 16'h0001), mk(1'b0, 16'hD001), mk(1'b0, 16'hD002),
                 mk(1'b0, 16'hD003), mk(1'b0, 16'hD004), mk(1'b1, 16'hD005)};
        rq = exp_q;
        dii_out_ready = 4'b1101;
        drive();
        for (int i = 0; i < 8; i++) step();
        check("t5_accepted", 32'(6 - rq.size()), 32'd4);
        check("t5_ring_in_ready", {31'd0, ring_in_ready}, 32'd0);
        check("t5_head_held", pk(dii_out[1]), pk(exp_q[0]));
        dii_out_ready = 4'hF;
        for (int i = 0; i < 30 && do_log[1].size() < 6; i++) step();
        check("t5_drained", 32'(do_log[1].size()), 32'd6);
        for (int k = 0; k < 6; k++)
            check($sformatf("t5_order%0d", k),
                  (k < do_log[1].size()) ? pk(do_log[1][k]) : 32'hDEAD0000, pk(exp_q[k]));
        check("t5_ring_in_ready_after", {31'd0, ring_in_ready}, 32'd1);

        // Ring output back-pressure for ten cycles.
        lq[2] = {mk(1'b0, 16'h2C00), mk(1'b1, 16'h2C01)};
        drive();
        step();
        check("t6_loaded", pk(ring_out), pk(mk(1'b0, 16'h2C00)));
        ring_out_ready = 1'b0;
        #1;
        check("t6_dii_in_blocked", {28'd0, dii_in_ready}, 32'd0);
        for (int i = 0; i < 10; i++) step();
        check("t6_held", pk(ring_out), pk(mk(1'b0, 16'h2C00)));
        check("t6_perf_stall", perf_stall_cycles, PERF ? 32'd10 : 32'd0);
        ring_out_ready = 1'b1;
        step();
        check("t6_second", pk(ring_out), pk(mk(1'b1, 16'h2C01)));
        step();
        check("t6_idle", {31'd0, ring_out.valid}, 32'd0);
        check("t6_perf_stall_after", perf_stall_cycles, PERF ? 32'd10 : 32'd0);

        // Asynchronous reset in the middle of packets.
        rq = {mk(1'b0, 16'h0003), mk(1'b0, 16'h3301), mk(1'b1, 16'h3302)};
        lq[1] = {mk(1'b0, 16'h1000), mk(1'b1, 16'h1001)};
        ring_out_ready = 1'b0;
        dii_out_ready  = 4'b0111;
        drive();
        step();
        step();
        check("t7_pre_local", ov(), 32'h8);
        check("t7_pre_ring_out", {31'd0, ring_out.valid}, 32'd1);
        #1 rstn = 1'b0;
        #1;
        check("t7_rst_ring_out", {31'd0, ring_out.valid}, 32'd0);
        check("t7_rst_dii_out", ov(), 32'd0);
        check("t7_rst_ring_in_ready", {31'd0, ring_in_ready}, 32'd1);
        check("t7_rst_dii_in_ready", {28'd0, dii_in_ready}, 32'd0);
        rq.delete();
        for (int p = 0; p < int'(PORTS); p++) lq[p].delete();
        ring_out_ready = 1'b1;
        dii_out_ready  = 4'hF;
        drive();
        @(posedge clk);
        @(posedge clk);
        #2 rstn = 1'b1;
        check("t7_perf_local_clr", perf_local_pkts, 32'd0);
        check("t7_perf_stall_clr", perf_stall_cycles, 32'd0);
        rq = {mk(1'b1, 16'h0001)};
        drive();
        step();
        check("t7_fresh_flit", pk(dii_out[1]), pk(mk(1'b1, 16'h0001)));
        check("t7_fresh_only_port1", ov(), 32'h2);
        step();
        check("t7_fresh_done", ov(), 32'd0);
        check("t7_fresh_no_ring", {31'd0, ring_out.valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
